axi_to_axilite_bridge: RTL and testbench

Protocol converter between the SoC AXI4 crossbar and AXI4-Lite peripherals such as the UART and GPIO slaves. It accepts full AXI4 bursts (FIXED/INCR/WRAP) on its slave side and issues one AXI4-Lite single-beat transaction per burst beat on its master side. It merges per-beat write responses into a single B response and returns per-beat read data with correct `rlast`/`rid`. Read and write paths are independent; each handles one burst at a time.

---
 rtl/uninasoc_pkg.sv | 42 ++++
 rtl/axi_burst_addr_gen.sv | 30 +++
 rtl/axi_to_axilite_bridge.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi_to_axilite_bridge.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uninasoc_pkg.sv
// Shared AXI4 / AXI4-Lite types, encodings and the burst-bridge FSM states.
package uninasoc_pkg;

    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 2;

    typedef logic [7:0] axi_len_t;
    typedef logic [2:0] axi_size_t;
    typedef logic [1:0] axi_burst_t;
    typedef logic       axi_lock_t;
    typedef logic [3:0] axi_cache_t;
    typedef logic [2:0] axi_prot_t;
    typedef logic [3:0] axi_qos_t;
    typedef logic [3:0] axi_region_t;
    typedef logic [1:0] axi_resp_t;

    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
    localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {W_IDLE, W_DATA, W_LITE, W_LRESP, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_LADDR, R_LDATA, R_SEND} rd_state_e;

    function automatic logic burst_unsupported(axi_size_t size, axi_burst_t burst, axi_len_t len);
        logic bad_wrap;
        bad_wrap = (burst == AXI_BURST_WRAP) &&
                   (len != 8'd1) && (len != 8'd3) && (len != 8'd7) && (len != 8'd15);
        return (size > 3'd2) || (burst == 2'b11) || bad_wrap;
    endfunction

    // Numeric order matches severity: DECERR > SLVERR > OKAY.
    function automatic axi_resp_t resp_merge(axi_resp_t a, axi_resp_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED / INCR / WRAP bursts.
module axi_burst_addr_gen
    import uninasoc_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  axi_size_t             size,
    input  axi_len_t              len,
    input  axi_burst_t            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] sum;

    always_comb begin
        step = ADDR_WIDTH'(1) << size;
        // mask covers the whole wrap window of (len+1) beats
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        sum  = addr + step;
        case (burst)
            AXI_BURST_FIXED: next_addr = addr;
            AXI_BURST_WRAP:  next_addr = (addr & ~mask) | (sum & mask);
            default:         next_addr = sum;
        endcase
    end

endmodule

// File: rtl/axi_to_axilite_bridge.sv
// AXI4 burst slave to AXI4-Lite single-beat master; independent read and write FSMs.
module axi_to_axilite_bridge
    import uninasoc_pkg::*;
#(
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int ID_WIDTH   = AXI_ID_WIDTH
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  axi_len_t                s_axi_awlen,
    input  axi_size_t               s_axi_awsize,
    input  axi_burst_t              s_axi_awburst,
    input  axi_lock_t               s_axi_awlock,
    input  axi_cache_t              s_axi_awcache,
    input  axi_prot_t               s_axi_awprot,
    input  axi_qos_t                s_axi_awqos,
    input  axi_region_t             s_axi_awregion,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output axi_resp_t               s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  axi_len_t                s_axi_arlen,
    input  axi_size_t               s_axi_arsize,
    input  axi_burst_t              s_axi_arburst,
    input  axi_lock_t               s_axi_arlock,
    input  axi_cache_t              s_axi_arcache,
    input  axi_prot_t               s_axi_arprot,
    input  axi_qos_t                s_axi_arqos,
    input  axi_region_t             s_axi_arregion,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output axi_resp_t               s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ADDR_WIDTH-1:0]   m_axilite_awaddr,
    output axi_prot_t               m_axilite_awprot,
    output logic                    m_axilite_awvalid,
    input  logic                    m_axilite_awready,
    output logic [DATA_WIDTH-1:0]   m_axilite_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axilite_wstrb,
    output logic                    m_axilite_wvalid,
    input  logic                    m_axilite_wready,
    input  axi_resp_t               m_axilite_bresp,
    input  logic                    m_axilite_bvalid,
    output logic                    m_axilite_bready,
    output logic [ADDR_WIDTH-1:0]   m_axilite_araddr,
    output axi_prot_t               m_axilite_arprot,
    output logic                    m_axilite_arvalid,
    input  logic                    m_axilite_arready,
    input  logic [DATA_WIDTH-1:0]   m_axilite_rdata,
    input  axi_resp_t               m_axilite_rresp,
    input  logic                    m_axilite_rvalid,
    output logic                    m_axilite_rready
);

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awqos, s_axi_awregion, s_axi_wlast,
                             s_axi_arlock, s_axi_arcache, s_axi_arqos, s_axi_arregion};

    // ---------------- write path ----------------
    wr_state_e             wstate;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_next;
    axi_len_t              w_len, w_cnt;
    axi_size_t             w_size;
    axi_burst_t            w_burst;
    axi_prot_t             w_prot;
    axi_resp_t             w_resp;
    logic                  w_bad, aw_pend, w_pend;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
        .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_next)
    );

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wstate          <= W_IDLE;
            w_id            <= '0;
            w_addr          <= '0;
            w_len           <= '0;
            w_cnt           <= '0;
            w_size          <= '0;
            w_burst         <= '0;
            w_prot          <= '0;
            w_resp          <= AXI_RESP_OKAY;
            w_bad           <= 1'b0;
            aw_pend         <= 1'b0;
            w_pend          <= 1'b0;
            m_axilite_wdata <= '0;
            m_axilite_wstrb <= '0;
        end else begin
            case (wstate)
                W_IDLE: if (s_axi_awvalid) begin
                    w_id    <= s_axi_awid;
                    w_addr  <= s_axi_awaddr;
                    w_len   <= s_axi_awlen;
                    w_size  <= s_axi_awsize;
                    w_burst <= s_axi_awburst;
                    w_prot  <= s_axi_awprot;
                    w_cnt   <= '0;
                    w_resp  <= AXI_RESP_OKAY;
                    w_bad   <= burst_unsupported(s_axi_awsize, s_axi_awburst, s_axi_awlen);
                    wstate  <= W_DATA;
                end
                W_DATA: if (s_axi_wvalid) begin
                    m_axilite_wdata <= s_axi_wdata;
                    m_axilite_wstrb <= s_axi_wstrb;
                    if (w_bad) begin
                        // drain the burst without touching the Lite side
                        if (w_cnt == w_len) begin
                            w_resp <= AXI_RESP_SLVERR;
                            wstate <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt + 8'd1;
                        end
                    end else begin
                        aw_pend <= 1'b1;
                        w_pend  <= 1'b1;
                        wstate  <= W_LITE;
                    end
                end
                W_LITE: begin
                    if (m_axilite_awready) aw_pend <= 1'b0;
                    if (m_axilite_wready)  w_pend  <= 1'b0;
                    if ((!aw_pend || m_axilite_awready) && (!w_pend || m_axilite_wready))
                        wstate <= W_LRESP;
                end
                W_LRESP: if (m_axilite_bvalid) begin
                    w_resp <= resp_merge(w_resp, m_axilite_bresp);
                    if (w_cnt == w_len) begin
                        wstate <= W_RESP;
                    end else begin
                        w_addr <= w_next;
                        w_cnt  <= w_cnt + 8'd1;
                        wstate <= W_DATA;
                    end
                end
                W_RESP: if (s_axi_bready) wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

    assign s_axi_awready     = (wstate == W_IDLE);
    assign s_axi_wready      = (wstate == W_DATA);
    assign s_axi_bvalid      = (wstate == W_RESP);
    assign s_axi_bid         = w_id;
    assign s_axi_bresp       = w_resp;
    assign m_axilite_awaddr  = w_addr;
    assign m_axilite_awprot  = w_prot;
    assign m_axilite_awvalid = aw_pend;
    assign m_axilite_wvalid  = w_pend;
    assign m_axilite_bready  = (wstate == W_LRESP);

    // ---------------- read path ----------------
    rd_state_e             rstate;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr, r_next;
    axi_len_t              r_len, r_cnt;
    axi_size_t             r_size;
    axi_burst_t            r_burst;
    axi_prot_t             r_prot;
    logic                  r_bad;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
        .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr(r_next)
    );

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rstate      <= R_IDLE;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_prot      <= '0;
            r_bad       <= 1'b0;
            s_axi_rdata <= '0;
            s_axi_rresp <= AXI_RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: if (s_axi_arvalid) begin
                    r_id    <= s_axi_arid;
                    r_addr  <= s_axi_araddr;
                    r_len   <= s_axi_arlen;
                    r_size  <= s_axi_arsize;
                    r_burst <= s_axi_arburst;
                    r_prot  <= s_axi_arprot;
                    r_cnt   <= '0;
                    r_bad   <= burst_unsupported(s_axi_arsize, s_axi_arburst, s_axi_arlen);
                    if (burst_unsupported(s_axi_arsize, s_axi_arburst, s_axi_arlen)) begin
                        s_axi_rdata <= '0;
                        s_axi_rresp <= AXI_RESP_SLVERR;
                        rstate      <= R_SEND;
                    end else begin
                        rstate <= R_LADDR;
                    end
                end
                R_LADDR: if (m_axilite_arready) rstate <= R_LDATA;
                R_LDATA: if (m_axilite_rvalid) begin
                    s_axi_rdata <= m_axilite_rdata;
                    s_axi_rresp <= m_axilite_rresp;
                    rstate      <= R_SEND;
                end
                R_SEND: if (s_axi_rready) begin
                    if (r_cnt == r_len) begin
                        rstate <= R_IDLE;
                    end else begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_addr <= r_next;
                        rstate <= r_bad ? R_SEND : R_LADDR;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi_arready     = (rstate == R_IDLE);
    assign s_axi_rvalid      = (rstate == R_SEND);
    assign s_axi_rlast       = (rstate == R_SEND) && (r_cnt == r_len);
    assign s_axi_rid         = r_id;
    assign m_axilite_araddr  = r_addr;
    assign m_axilite_arprot  = r_prot;
    assign m_axilite_arvalid = (rstate == R_LADDR);
    assign m_axilite_rready  = (rstate == R_LDATA);

endmodule

// File: tb/tb_axi_to_axilite_bridge.sv
// Scoreboard bench: AXI4 master tasks upstream, behavioural AXI4-Lite slave downstream.
module tb_axi_to_axilite_bridge;
    import uninasoc_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [IW-1:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [AW-1:0] s_axi_awaddr, s_axi_araddr, m_awaddr, m_araddr;
    logic [7:0]    s_axi_awlen, s_axi_arlen;
    logic [2:0]    s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot, m_awprot, m_arprot;
    logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp, m_bresp, m_rresp;
    logic          s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [DW-1:0] s_axi_wdata, s_axi_rdata, m_wdata, m_rdata;
    logic [3:0]    s_axi_wstrb, m_wstrb;
    logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;

    axi_to_axilite_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clock_i(clk), .reset_ni(rst_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'h0), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(4'h0),
        .s_axi_awregion(4'h0), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'h0), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(4'h0),
        .s_axi_arregion(4'h0), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axilite_awaddr(m_awaddr), .m_axilite_awprot(m_awprot), .m_axilite_awvalid(m_awvalid),
        .m_axilite_awready(m_awready), .m_axilite_wdata(m_wdata), .m_axilite_wstrb(m_wstrb),
        .m_axilite_wvalid(m_wvalid), .m_axilite_wready(m_wready), .m_axilite_bresp(m_bresp),
        .m_axilite_bvalid(m_bvalid), .m_axilite_bready(m_bready), .m_axilite_araddr(m_araddr),
        .m_axilite_arprot(m_arprot), .m_axilite_arvalid(m_arvalid), .m_axilite_arready(m_arready),
        .m_axilite_rdata(m_rdata), .m_axilite_rresp(m_rresp), .m_axilite_rvalid(m_rvalid),
        .m_axilite_rready(m_rready)
    );

    typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} rbeat_t;
    typedef struct packed {logic [IW-1:0] id; logic [1:0] resp;} bexp_t;

    logic [34:0] exp_aw_q[$];   // {prot, addr}
    logic [35:0] exp_w_q[$];    // {strb, data}
    logic [34:0] exp_ar_q[$];   // {prot, addr}
    logic [1:0]  lite_bresp_q[$];
    rbeat_t      exp_r_q[$];
    bexp_t       exp_b_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int aw_delay = 0;
    int w_delay = 0;
    int lite_b_cnt = 0;
    logic [AW-1:0] last_ar = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] lite_rd_data(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // ---------------- AXI4-Lite slave ----------------
    initial begin
        logic [34:0] e;
        m_awready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_awvalid) begin
                repeat (aw_delay) @(negedge clk);
                if (m_awvalid) begin
                    m_awready = 1'b1;
                    n_vec++;
                    if (exp_aw_q.size() == 0) begin
                        n_err++;
                        $display("FAIL lite_aw unexpected: addr=%h, none expected", m_awaddr);
                    end else begin
                        e = exp_aw_q.pop_front();
                        if ({m_awprot, m_awaddr} !== e)
                            begin n_err++; $display("FAIL lite_aw got prot=%0d addr=%h want prot=%0d addr=%h", m_awprot, m_awaddr, e[34:32], e[31:0]); end
                    end
                    @(negedge clk);
                    m_awready = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [35:0] e;
        m_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_wvalid) begin
                repeat (w_delay) @(negedge clk);
                if (m_wvalid) begin
                    m_wready = 1'b1;
                    n_vec++;
                    if (exp_w_q.size() == 0) begin
                        n_err++;
                        $display("FAIL lite_w unexpected: data=%h, none expected", m_wdata);
                    end else begin
                        e = exp_w_q.pop_front();
                        if ({m_wstrb, m_wdata} !== e)
                            begin n_err++; $display("FAIL lite_w got strb=%h data=%h want strb=%h data=%h", m_wstrb, m_wdata, e[35:32], e[31:0]); end
                    end
                    @(negedge clk);
                    m_wready = 1'b0;
                end
            end
        end
    end

    initial begin
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
        forever begin
            @(negedge clk);
            if (m_bready) begin
                m_bvalid = 1'b1;
                m_bresp  = (lite_bresp_q.size() != 0) ? lite_bresp_q.pop_front() : AXI_RESP_OKAY;
                lite_b_cnt++;
                @(negedge clk);
                m_bvalid = 1'b0;
            end
        end
    end

    initial begin
        logic [34:0] e;
        m_arready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_arvalid) begin
                m_arready = 1'b1;
                last_ar = m_araddr;
                n_vec++;
                if (exp_ar_q.size() == 0) begin
                    n_err++;
                    $display("FAIL lite_ar unexpected: addr=%h, none expected", m_araddr);
                end else begin
                    e = exp_ar_q.pop_front();
                    if ({m_arprot, m_araddr} !== e)
                        begin n_err++; $display("FAIL lite_ar got prot=%0d addr=%h want prot=%0d addr=%h", m_arprot, m_araddr, e[34:32], e[31:0]); end
                end
                @(negedge clk);
                m_arready = 1'b0;
            end
        end
    end

    initial begin
        m_rvalid = 1'b0;
        m_rdata  = '0;
        m_rresp  = 2'b00;
        forever begin
            @(negedge clk);
            if (m_rready) begin
                m_rvalid = 1'b1;
                m_rdata  = lite_rd_data(last_ar);
                m_rresp  = AXI_RESP_OKAY;
                @(negedge clk);
                m_rvalid = 1'b0;
            end
        end
    end

    // ---------------- AXI4 master tasks (entered on a falling edge) ----------------
    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot);
        int t = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awprot = prot; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && t < 200) begin @(negedge clk); t++; end
        n_vec++;
        if (!s_axi_awready) begin n_err++; $display("FAIL aw_handshake timeout: awready=%b want 1", s_axi_awready); end
        hs_cyc = cyc;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] data, input logic [3:0] strb);
        int t = 0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        while (!s_axi_wready && t < 200) begin @(negedge clk); t++; end
        n_vec++;
        if (!s_axi_wready) begin n_err++; $display("FAIL w_handshake timeout: wready=%b want 1", s_axi_wready); end
        @(negedge clk);
        s_axi_wvalid = 1'b0;
    endtask

    task automatic b_recv(output int lat);
        int t = 0;
        bexp_t e;
        lat = -1;
        s_axi_bready = 1'b1;
        while (!s_axi_bvalid && t < 200) begin @(negedge clk); t++; end
        n_vec++;
        if (!s_axi_bvalid) begin
            n_err++; $display("FAIL b_wait timeout: bvalid=%b want 1", s_axi_bvalid);
        end else begin
            lat = cyc - hs_cyc;
            e = (exp_b_q.size() != 0) ? exp_b_q.pop_front() : '1;
            if ({s_axi_bid, s_axi_bresp} !== e)
                begin n_err++; $display("FAIL b_resp got id=%0d resp=%0d want id=%0d resp=%0d", s_axi_bid, s_axi_bresp, e.id, e.resp); end
        end
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot);
        int t = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arprot = prot; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && t < 200) begin @(negedge clk); t++; end
        n_vec++;
        if (!s_axi_arready) begin n_err++; $display("FAIL ar_handshake timeout: arready=%b want 1", s_axi_arready); end
        hs_cyc = cyc;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic r_recv(input int stall, output int lat);
        int t = 0;
        rbeat_t e, snap;
        lat = -1;
        while (!s_axi_rvalid && t < 200) begin @(negedge clk); t++; end
        n_vec++;
        if (!s_axi_rvalid) begin
            n_err++; $display("FAIL r_wait timeout: rvalid=%b want 1", s_axi_rvalid);
            return;
        end
        lat = cyc - hs_cyc;
        if (stall > 0) begin
            snap = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
            repeat (stall) @(negedge clk);
            n_vec++;
            if ({s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} !== {1'b1, snap})
                begin n_err++; $display("FAIL r_hold got valid=%b data=%h want valid=1 data=%h", s_axi_rvalid, s_axi_rdata, snap.data); end
        end
        s_axi_rready = 1'b1;
        e = (exp_r_q.size() != 0) ? exp_r_q.pop_front() : '1;
        n_vec++;
        if ({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} !== e)
            begin n_err++; $display("FAIL r_beat got id=%0d data=%h resp=%0d last=%b want id=%0d data=%h resp=%0d last=%b",
                                    s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, e.id, e.data, e.resp, e.last); end
        @(negedge clk);
        s_axi_rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({s_axi_awready, s_axi_arready} !== 2'b11)
            begin n_err++; $display("FAIL reset_ready got aw/ar=%b want 11", {s_axi_awready, s_axi_arready}); end
        n_vec++;
        if ({s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 9'b0)
            begin n_err++; $display("FAIL reset_valids got %b want 000000000",
                {s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}); end
        n_vec++;
        if ({s_axi_bid, s_axi_bresp, s_axi_rdata, s_axi_rresp, m_awaddr, m_araddr} !== '0)
            begin n_err++; $display("FAIL reset_payload got rdata=%h awaddr=%h want 0", s_axi_rdata, m_awaddr); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        int lat;
        exp_aw_q.push_back({3'd0, 32'h100});
        exp_w_q.push_back({4'hF, 32'hDEADBEEF});
        exp_b_q.push_back('{id: 2'd2, resp: AXI_RESP_OKAY});
        aw_send(2'd2, 32'h100, 8'd0, 3'd2, AXI_BURST_INCR, 3'd0);
        w_send(32'hDEADBEEF, 4'hF);
        b_recv(lat);
        n_vec++;
        if (lat !== 4) begin n_err++; $display("FAIL write_latency got %0d want 4", lat); end
    endtask

    task automatic test_incr_read();
        int lat;
        logic [AW-1:0] a [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
        for (int i = 0; i < 4; i++) begin
            exp_ar_q.push_back({3'd0, a[i]});
            exp_r_q.push_back('{id: 2'd1, data: lite_rd_data(a[i]), resp: AXI_RESP_OKAY, last: (i == 3)});
        end
        ar_send(2'd1, 32'h200, 8'd3, 3'd2, AXI_BURST_INCR, 3'd0);
        for (int i = 0; i < 4; i++) begin
            r_recv((i == 1) ? 5 : 0, lat);
            if (i == 0) begin
                n_vec++;
                if (lat !== 3) begin n_err++; $display("FAIL read_latency got %0d want 3", lat); end
            end
        end
    endtask

    task automatic test_wrap_read();
        int lat;
        logic [AW-1:0] a [4] = '{32'h208, 32'h20C, 32'h200, 32'h204};
        for (int i = 0; i < 4; i++) begin
            exp_ar_q.push_back({3'd5, a[i]});
            exp_r_q.push_back('{id: 2'd3, data: lite_rd_data(a[i]), resp: AXI_RESP_OKAY, last: (i == 3)});
        end
        ar_send(2'd3, 32'h208, 8'd3, 3'd2, AXI_BURST_WRAP, 3'd5);
        for (int i = 0; i < 4; i++) r_recv(0, lat);
    endtask

    task automatic test_fixed_write();
        int lat;
        logic [DW-1:0] d [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        for (int i = 0; i < 3; i++) begin
            exp_aw_q.push_back({3'd2, 32'h40});
            exp_w_q.push_back({4'h3, d[i]});
        end
        exp_b_q.push_back('{id: 2'd0, resp: AXI_RESP_OKAY});
        aw_send(2'd0, 32'h40, 8'd2, 3'd2, AXI_BURST_FIXED, 3'd2);
        for (int i = 0; i < 3; i++) w_send(d[i], 4'h3);
        b_recv(lat);
    endtask

    task automatic test_merge_resp(input int dly);
        int lat, b0;
        aw_delay = dly;
        b0 = lite_b_cnt;
        lite_bresp_q.push_back(AXI_RESP_OKAY);
        lite_bresp_q.push_back(AXI_RESP_SLVERR);
        exp_aw_q.push_back({3'd0, 32'h300});
        exp_aw_q.push_back({3'd0, 32'h304});
        exp_w_q.push_back({4'hF, 32'hA0A0_0000});
        exp_w_q.push_back({4'hC, 32'hB0B0_0001});
        exp_b_q.push_back('{id: 2'd1, resp: AXI_RESP_SLVERR});
        aw_send(2'd1, 32'h300, 8'd1, 3'd2, AXI_BURST_INCR, 3'd0);
        w_send(32'hA0A0_0000, 4'hF);
        w_send(32'hB0B0_0001, 4'hC);
        b_recv(lat);
        n_vec++;
        if (lite_b_cnt - b0 !== 2)
            begin n_err++; $display("FAIL merge_lite_b_count got %0d want 2", lite_b_cnt - b0); end
        aw_delay = 0;
    endtask

    task automatic test_unsupported_read();
        int lat;
        for (int i = 0; i < 2; i++)
            exp_r_q.push_back('{id: 2'd2, data: 32'h0, resp: AXI_RESP_SLVERR, last: (i == 1)});
        ar_send(2'd2, 32'h400, 8'd1, 3'd3, AXI_BURST_INCR, 3'd0);
        r_recv(5, lat);
        r_recv(0, lat);
    endtask

    task automatic test_unsupported_write();
        int lat;
        exp_b_q.push_back('{id: 2'd3, resp: AXI_RESP_SLVERR});
        aw_send(2'd3, 32'h500, 8'd2, 3'd2, AXI_BURST_WRAP, 3'd0);
        for (int i = 0; i < 3; i++) w_send(32'hC0DE_0000 + i, 4'hF);
        b_recv(lat);
    endtask

    task automatic test_reset_midburst();
        int lat;
        aw_delay = 10;
        exp_aw_q.push_back({3'd0, 32'h600});
        exp_aw_q.push_back({3'd0, 32'h604});
        exp_w_q.push_back({4'hF, 32'h6000_0000});
        exp_w_q.push_back({4'hF, 32'h6000_0001});
        aw_send(2'd0, 32'h600, 8'd3, 3'd2, AXI_BURST_INCR, 3'd0);
        w_send(32'h6000_0000, 4'hF);
        w_send(32'h6000_0001, 4'hF);
        repeat (2) @(negedge clk);
        n_vec++;
        if (m_awvalid !== 1'b1) begin n_err++; $display("FAIL midburst_pending got awvalid=%b want 1", m_awvalid); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({m_awvalid, m_wvalid, m_bready, s_axi_wready, s_axi_bvalid, s_axi_awready} !== 6'b000001)
            begin n_err++; $display("FAIL midburst_reset got %b want 000001",
                {m_awvalid, m_wvalid, m_bready, s_axi_wready, s_axi_bvalid, s_axi_awready}); end
        aw_delay = 0;
        repeat (12) @(negedge clk);
        exp_aw_q.delete(); exp_w_q.delete(); lite_bresp_q.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_aw_q.push_back({3'd0, 32'h700});
        exp_w_q.push_back({4'hF, 32'h1234_5678});
        exp_b_q.push_back('{id: 2'd1, resp: AXI_RESP_OKAY});
        aw_send(2'd1, 32'h700, 8'd0, 3'd2, AXI_BURST_INCR, 3'd0);
        w_send(32'h1234_5678, 4'hF);
        b_recv(lat);
    endtask

    initial begin
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;

        test_reset();
        test_single_write();
        test_incr_read();
        test_wrap_read();
        test_fixed_write();
        test_merge_resp(0);
        test_merge_resp(3);
        test_unsupported_read();
        test_unsupported_write();
        test_reset_midburst();

        repeat (4) @(negedge clk);
        n_vec++;
        if (exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_r_q.size() + exp_b_q.size() != 0)
            begin n_err++; $display("FAIL scoreboard_drain got aw=%0d w=%0d ar=%0d r=%0d b=%0d left want 0",
                exp_aw_q.size(), exp_w_q.size(), exp_ar_q.size(), exp_r_q.size(), exp_b_q.size()); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
